// File: rtl/mem_responder.sv
// mem_responder: single-outstanding line memory model for a cache miss port.
// Reads stream LINE_BEATS beats after LATENCY idle cycles; writes take one
// masked beat each. Ports:
//   clk, reset (sync, active-low)
//   mem_req_*      : request channel (valid/ready, rw, addr, tag)
//   mem_req_data_* : write beat channel (valid/ready, bits, mask, offset)
//   mem_resp_*     : read beat channel (valid, data, tag), no backpressure
module mem_responder #(
    parameter int ADDR_BITS  = 28,
    parameter int TAG_BITS   = 5,
    parameter int DATA_BITS  = 128,
    parameter int LINE_BEATS = 4,
    parameter int MEM_LINES  = 1024,
    parameter int LATENCY    = 4,
    localparam int OFF_W  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1,
    localparam int MASK_W = DATA_BITS / 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_req_valid,
    output logic                 mem_req_ready,
    input  logic                 mem_req_rw,
    input  logic [ADDR_BITS-1:0] mem_req_addr,
    input  logic [TAG_BITS-1:0]  mem_req_tag,
    input  logic                 mem_req_data_valid,
    output logic                 mem_req_data_ready,
    input  logic [DATA_BITS-1:0] mem_req_data_bits,
    input  logic [MASK_W-1:0]    mem_req_data_mask,
    input  logic [OFF_W-1:0]     mem_req_data_offset,
    output logic                 mem_resp_valid,
    output logic [DATA_BITS-1:0] mem_resp_data,
    output logic [TAG_BITS-1:0]  mem_resp_tag
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int AW    = IDX_W + OFF_W;
    localparam int DEPTH = 1 << AW;

    localparam logic [3:0] LAT_M1 =
        (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RWAIT,
        RRESP,
        WDATA
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TAG_BITS-1:0] tag_q, tag_d;
    logic               wr_en;

    // Storage is deliberately left out of reset so contents survive it.
    logic [DATA_BITS-1:0] mem_q [DEPTH];

    // Upper address bits alias onto the stored lines.
    logic unused_addr;
    assign unused_addr = ^mem_req_addr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        idx_d   = idx_q;
        tag_d   = tag_q;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_req_valid) begin
                    idx_d  = mem_req_addr[IDX_W-1:0];
                    tag_d  = mem_req_tag;
                    beat_d = '0;
                    if (mem_req_rw) begin
                        state_d = WDATA;
                    end else if (LATENCY > 0) begin
                        state_d = RWAIT;
                        cnt_d   = LAT_M1;
                    end else begin
                        state_d = RRESP;
                    end
                end
            end
            RWAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RRESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RRESP: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + OFF_W'(1);
                end
            end
            WDATA: begin
                if (mem_req_data_valid) begin
                    wr_en   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A beat presented on the reset edge must not land in storage.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (mem_req_data_mask[b]) begin
                    mem_q[{idx_q, mem_req_data_offset}][8*b +: 8]
                        <= mem_req_data_bits[8*b +: 8];
                end
            end
        end
    end

    assign mem_req_ready      = (state_q == IDLE);
    assign mem_req_data_ready = (state_q == WDATA);
    assign mem_resp_valid     = (state_q == RRESP);
    assign mem_resp_data      = mem_resp_valid ? mem_q[{idx_q, beat_q}] : '0;
    assign mem_resp_tag       = mem_resp_valid ? tag_q : '0;

endmodule
